// File: rtl/display_mux.sv
// Scanned driver for common-anode seven-segment digits: latches a packed digit word and lights
// one digit per slot, with a blank guard cycle, leading-zero suppression and whole-display blink.
module display_mux #(
  parameter int unsigned DIGITOS       = 4,
  parameter int unsigned DIVISOR       = 50000,
  parameter int unsigned HEX           = 0,
  parameter int unsigned PISCA_QUADROS = 64
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [4*DIGITOS-1:0]   Entrada,
  input  logic                   Carrega,
  input  logic                   ApagaZeros,
  input  logic                   Piscar,
  output logic [6:0]             Saida,
  output logic [DIGITOS-1:0]     Anodo
);

  localparam int unsigned PW = $clog2(DIVISOR);
  localparam int unsigned DW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
  localparam int unsigned FW = (PISCA_QUADROS > 1) ? $clog2(PISCA_QUADROS) : 1;

  logic [4*DIGITOS-1:0] valor_q, valor_d;
  logic [PW-1:0]        p_q, p_d;
  logic [DW-1:0]        d_q, d_d;
  logic [FW-1:0]        f_q, f_d;
  logic                 fase_q, fase_d;
  logic [6:0]           saida_d;
  logic [DIGITOS-1:0]   anodo_d;
  logic [DIGITOS:0]     upper_zero;
  logic [3:0]           cur_nib;
  logic                 cur_supp;
  logic                 p_last, d_last, f_last;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0001100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    if (HEX == 0 && n > 4'd9) s = 7'b1111111;
    return s;
  endfunction

  always_comb begin
    p_last  = (p_q == PW'(DIVISOR - 1));
    d_last  = (d_q == DW'(DIGITOS - 1));
    f_last  = (f_q == FW'(PISCA_QUADROS - 1));
    valor_d = Carrega ? Entrada : valor_q;
    p_d     = p_last ? '0 : p_q + 1'b1;
    d_d     = d_q;
    f_d     = f_q;
    fase_d  = fase_q;
    if (p_last) d_d = d_last ? '0 : d_q + 1'b1;
    if (p_last && d_last) begin
      f_d = f_last ? '0 : f_q + 1'b1;
      if (f_last) fase_d = ~fase_q;
    end
  end

  // upper_zero[i] is set when every nibble from i upward is zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[DIGITOS] = 1'b1;
    for (int i = DIGITOS - 1; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (valor_q[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    cur_nib  = '0;
    cur_supp = 1'b0;
    anodo_d  = '1;
    for (int i = 0; i < DIGITOS; i++) begin
      if (d_q == DW'(i)) begin
        cur_nib    = valor_q[4*i +: 4];
        cur_supp   = ApagaZeros && (i != 0) && upper_zero[i];
        anodo_d[i] = 1'b0;
      end
    end
    saida_d = cur_supp ? 7'b1111111 : decode(cur_nib);
    if (p_q == '0 || (Piscar && !fase_q)) begin
      anodo_d = '1;
      saida_d = 7'b1111111;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      valor_q <= '0;
      p_q     <= '0;
      d_q     <= '0;
      f_q     <= '0;
      fase_q  <= 1'b1;
      Saida   <= 7'b1111111;
      Anodo   <= '1;
    end else begin
      valor_q <= valor_d;
      p_q     <= p_d;
      d_q     <= d_d;
      f_q     <= f_d;
      fase_q  <= fase_d;
      Saida   <= saida_d;
      Anodo   <= anodo_d;
    end
  end

endmodule

// File: tb/tb_display_mux.sv
// Bench for display_mux: two instances (HEX=0 and HEX=1) share stimulus and are checked against
// a model that derives the scan position from the count of edges since reset release.
module tb_display_mux;

  localparam int DIG = 4;
  localparam int DIV = 4;
  localparam int PQ  = 2;

  logic            Clock = 1'b0;
  logic            Reset = 1'b0;
  logic [15:0]     Entrada = '0;
  logic            Carrega = 1'b0;
  logic            ApagaZeros = 1'b0;
  logic            Piscar = 1'b0;
  logic [6:0]      saida0, saida1;
  logic [3:0]      anodo0, anodo1;

  int total = 0;
  int bad   = 0;

  // Reference state: edges since release and the value the display should hold.
  int          n_edges;
  logic [15:0] valor_m;
  logic [3:0]  exp_an;
  logic [6:0]  exp_s0, exp_s1;

  display_mux #(.DIGITOS(DIG), .DIVISOR(DIV), .HEX(0), .PISCA_QUADROS(PQ)) dut0 (
    .Clock(Clock), .Reset(Reset), .Entrada(Entrada), .Carrega(Carrega),
    .ApagaZeros(ApagaZeros), .Piscar(Piscar), .Saida(saida0), .Anodo(anodo0)
  );

  display_mux #(.DIGITOS(DIG), .DIVISOR(DIV), .HEX(1), .PISCA_QUADROS(PQ)) dut1 (
    .Clock(Clock), .Reset(Reset), .Entrada(Entrada), .Carrega(Carrega),
    .ApagaZeros(ApagaZeros), .Piscar(Piscar), .Saida(saida1), .Anodo(anodo1)
  );

  always #5 Clock = ~Clock;

  function automatic logic [6:0] seg_of(input int v, input bit hex);
    case (v)
      0: return 7'b0000001;   1: return 7'b1001111;   2: return 7'b0010010;
      3: return 7'b0000110;   4: return 7'b1001100;   5: return 7'b0100100;
      6: return 7'b0100000;   7: return 7'b0001111;   8: return 7'b0000000;
      9: return 7'b0001100;
      default: begin
        if (!hex) return 7'b1111111;
        case (v)
          10: return 7'b0001000;  11: return 7'b1100000;  12: return 7'b0110001;
          13: return 7'b1000010;  14: return 7'b0110000;  default: return 7'b0111000;
        endcase
      end
    endcase
  endfunction

  // Predict the outputs of the coming edge from the pre-edge scan position, then take the edge.
  task automatic tick();
    int p, d, frames, nib;
    bit visible, supp;
    p       = n_edges % DIV;
    d       = (n_edges / DIV) % DIG;
    frames  = n_edges / (DIG * DIV);
    visible = ((frames / PQ) % 2) == 0;
    if (p == 0 || (Piscar && !visible)) begin
      exp_an = 4'hF;
      exp_s0 = 7'h7F;
      exp_s1 = 7'h7F;
    end else begin
      exp_an = ~(4'(1) << d);
      nib    = int'(valor_m >> (4 * d)) & 15;
      supp   = ApagaZeros && d >= 1 && (valor_m >> (4 * d)) == 16'h0;
      exp_s0 = supp ? 7'h7F : seg_of(nib, 1'b0);
      exp_s1 = supp ? 7'h7F : seg_of(nib, 1'b1);
    end
    if (Carrega) valor_m = Entrada;
    n_edges++;
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset   = 1'b0;
    n_edges = 0;
    valor_m = '0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #1;
    total++;
    if (anodo0 !== 4'hF || saida0 !== 7'h7F) begin
      bad++;
      $display("FAIL reset_state: anodo=%b saida=%b required anodo=1111 saida=1111111", anodo0, saida0);
    end
    @(posedge Clock);
    #1;
    Reset   = 1'b0;
    n_edges = 0;
    valor_m = '0;
  endtask

  task automatic test_first_scan();
    logic [3:0] an_req [6];
    logic [6:0] s_req [6];
    an_req = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD};
    s_req  = '{7'h7F, 7'h01, 7'h01, 7'h01, 7'h7F, 7'h01};
    for (int e = 0; e < 6; e++) begin
      tick();
      total++;
      if (anodo0 !== an_req[e] || saida0 !== s_req[e]) begin
        bad++;
        $display("FAIL first_scan edge%0d: anodo=%b saida=%b required anodo=%b saida=%b",
                 e + 1, anodo0, saida0, an_req[e], s_req[e]);
      end
    end
  endtask

  task automatic test_load_decode();
    logic [6:0] seen [4];
    logic [6:0] req [4];
    req = '{7'h4F, 7'h01, 7'h06, 7'h0C};
    for (int i = 0; i < 4; i++) seen[i] = 7'h00;
    Entrada = 16'h9301;
    Carrega = 1'b1;
    tick();
    Carrega = 1'b0;
    Entrada = 16'($urandom);
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if (anodo0 !== exp_an || saida0 !== exp_s0) begin
        bad++;
        $display("FAIL load_decode cyc%0d: anodo=%b saida=%b required anodo=%b saida=%b",
                 c, anodo0, saida0, exp_an, exp_s0);
      end
      for (int i = 0; i < 4; i++) if (anodo0 == ~(4'(1) << i)) seen[i] = saida0;
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (seen[i] !== req[i]) begin
        bad++;
        $display("FAIL load_digit%0d: saida=%b required %b", i, seen[i], req[i]);
      end
    end
  endtask

  task automatic test_hex();
    logic [6:0] seen0 [4];
    logic [6:0] seen1 [4];
    logic [6:0] req0 [4];
    logic [6:0] req1 [4];
    req0 = '{7'h7F, 7'h24, 7'h7F, 7'h7F};
    req1 = '{7'h31, 7'h24, 7'h08, 7'h38};
    for (int i = 0; i < 4; i++) begin
      seen0[i] = 7'h00;
      seen1[i] = 7'h00;
    end
    Entrada = 16'hFA5C;
    Carrega = 1'b1;
    tick();
    Carrega = 1'b0;
    for (int c = 0; c < 17; c++) begin
      tick();
      total++;
      if (anodo1 !== exp_an || saida0 !== exp_s0 || saida1 !== exp_s1) begin
        bad++;
        $display("FAIL hex cyc%0d: anodo=%b s0=%b s1=%b required anodo=%b s0=%b s1=%b",
                 c, anodo1, saida0, saida1, exp_an, exp_s0, exp_s1);
      end
      for (int i = 0; i < 4; i++) begin
        if (anodo0 == ~(4'(1) << i)) seen0[i] = saida0;
        if (anodo1 == ~(4'(1) << i)) seen1[i] = saida1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (seen0[i] !== req0[i] || seen1[i] !== req1[i]) begin
        bad++;
        $display("FAIL hex_digit%0d: hex0=%b hex1=%b required hex0=%b hex1=%b",
                 i, seen0[i], seen1[i], req0[i], req1[i]);
      end
    end
  endtask

  task automatic test_zero_suppress();
    logic [15:0] vals [2];
    logic [6:0]  req [2][4];
    logic [6:0]  seen [4];
    vals = '{16'h0070, 16'h0000};
    req  = '{'{7'h01, 7'h0F, 7'h7F, 7'h7F}, '{7'h01, 7'h7F, 7'h7F, 7'h7F}};
    ApagaZeros = 1'b1;
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < 4; i++) seen[i] = 7'h00;
      Entrada = vals[v];
      Carrega = 1'b1;
      tick();
      Carrega = 1'b0;
      for (int c = 0; c < 17; c++) begin
        tick();
        total++;
        if (anodo0 !== exp_an || saida0 !== exp_s0) begin
          bad++;
          $display("FAIL lzs v%0d cyc%0d: anodo=%b saida=%b required anodo=%b saida=%b",
                   v, c, anodo0, saida0, exp_an, exp_s0);
        end
        for (int i = 0; i < 4; i++) if (anodo0 == ~(4'(1) << i)) seen[i] = saida0;
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (seen[i] !== req[v][i]) begin
          bad++;
          $display("FAIL lzs v%0d digit%0d: saida=%b required %b", v, i, seen[i], req[v][i]);
        end
      end
    end
    ApagaZeros = 1'b0;
  endtask

  task automatic test_blink();
    int off_cnt;
    apply_reset();
    Entrada = 16'h1234;
    Carrega = 1'b1;
    Piscar  = 1'b1;
    off_cnt = 0;
    for (int e = 1; e <= 100; e++) begin
      tick();
      Carrega = 1'b0;
      total++;
      if (anodo0 !== exp_an || saida0 !== exp_s0) begin
        bad++;
        $display("FAIL blink edge%0d: anodo=%b saida=%b required anodo=%b saida=%b",
                 e, anodo0, saida0, exp_an, exp_s0);
      end
      if (e >= 33 && e <= 64 && anodo0 == 4'hF) off_cnt++;
    end
    total++;
    if (off_cnt != 32) begin
      bad++;
      $display("FAIL blink_off_half: dark_edges=%0d required 32", off_cnt);
    end
    apply_reset();
    for (int e = 0; e < 41; e++) tick();
    Piscar = 1'b0;
    tick();
    total++;
    if (anodo0 !== 4'b1011) begin
      bad++;
      $display("FAIL blink_release: anodo=%b required 1011", anodo0);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] an_req [6];
    logic [6:0] s_req [6];
    an_req = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD};
    s_req  = '{7'h7F, 7'h01, 7'h01, 7'h01, 7'h7F, 7'h01};
    apply_reset();
    Entrada = 16'h5555;
    Carrega = 1'b1;
    tick();
    Carrega = 1'b0;
    for (int e = 1; e < 10; e++) tick();
    total++;
    if (anodo0 !== 4'b1011 || saida0 !== 7'h24) begin
      bad++;
      $display("FAIL mid_precond: anodo=%b saida=%b required anodo=1011 saida=0100100",
               anodo0, saida0);
    end
    Reset   = 1'b1;
    Carrega = 1'b1;
    Entrada = 16'h8888;
    #1;
    total++;
    if (anodo0 !== 4'hF || saida0 !== 7'h7F) begin
      bad++;
      $display("FAIL mid_async_blank: anodo=%b saida=%b required anodo=1111 saida=1111111",
               anodo0, saida0);
    end
    @(posedge Clock);
    #1;
    total++;
    if (anodo0 !== 4'hF || saida0 !== 7'h7F) begin
      bad++;
      $display("FAIL mid_held_blank: anodo=%b saida=%b required anodo=1111 saida=1111111",
               anodo0, saida0);
    end
    Reset   = 1'b0;
    Carrega = 1'b0;
    n_edges = 0;
    valor_m = '0;
    for (int e = 0; e < 6; e++) begin
      tick();
      total++;
      if (anodo0 !== an_req[e] || saida0 !== s_req[e]) begin
        bad++;
        $display("FAIL mid_restart edge%0d: anodo=%b saida=%b required anodo=%b saida=%b",
                 e + 1, anodo0, saida0, an_req[e], s_req[e]);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      Carrega = ($urandom_range(3) == 0);
      Entrada = 16'($urandom) & {{4{1'($urandom_range(1))}}, {4{1'($urandom_range(1))}},
                                 {4{1'($urandom_range(1))}}, 4'hF};
      if ($urandom_range(15) == 0) ApagaZeros = ~ApagaZeros;
      if ($urandom_range(31) == 0) Piscar = ~Piscar;
      tick();
      total++;
      if (anodo0 !== exp_an || anodo1 !== exp_an || saida0 !== exp_s0 || saida1 !== exp_s1) begin
        bad++;
        $display("FAIL random cyc%0d: anodo=%b/%b saida=%b/%b required anodo=%b saida=%b/%b",
                 c, anodo0, anodo1, saida0, saida1, exp_an, exp_s0, exp_s1);
      end
      total++;
      if ($countones(~anodo0) > 1) begin
        bad++;
        $display("FAIL one_hot cyc%0d: anodo=%b required at most one low bit", c, anodo0);
      end
    end
    Carrega = 1'b0;
  endtask

  initial begin
    n_edges = 0;
    valor_m = '0;
    test_reset();
    test_first_scan();
    test_load_decode();
    test_hex();
    test_zero_suppress();
    test_blink();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
